cart_sram_transfer: RTL
=======================

// Module: cart_sram_transfer
// PURPOSE
// - Bridge-side byte port to banked cartridge SRAM (0xA000-0xBFFF window, MBC-style bank register).
// - Services APF bridge reads (save dump) and writes (save restore); bank computed from address, not sequential.
// - Sits between core bridge decode and cartridge tran pins, alongside the cart bus arbiter in clk_74a.
// PARAMETERS
// - BANK_ADDR_BITS  13        byte-offset bits per bank (8 KiB)
// - BANK_COUNT      16        SRAM banks present; addresses beyond BANK_COUNT*2^BANK_ADDR_BITS are out of range
// - READ_DELAY      15        extra cycles cart_read held before data sampled (total READ_DELAY+1)
// - WRITE_DELAY     63        extra cycles cart_write held for bank/data writes (total WRITE_DELAY+1)
// - BANK_REG_ADDR   16'h4000  cart address of bank-select register
// - SRAM_BASE       16'hA000  cart address of SRAM window
// PORTS
// - clk_74a              in   1   sole clock
// - reset                in   1   synchronous, active-high reset
// - bridge_rd            in   1   bridge read strobe; rising edge starts a read
// - bridge_wr            in   1   bridge write strobe; rising edge starts a write
// - bridge_8bit_addr     in   32  byte address within save image
// - bridge_8bit_wr_data  in   8   write byte, captured on bridge_wr rising edge
// - bridge_8bit_rd_data  out  8   read byte, valid after busy falls
// - busy                 out  1   high from accepted strobe edge until transaction complete
// - cart_address         out  16  cart address bus
// - cart_tran_bank0_out  out  4   [7:4] = {1'b0, ~cart_write, ~cart_read, cart_write} (WR_n, RD_n, CS)
// - cart_tran_bank1_in   in   8   cart data in
// - cart_tran_bank1_out  out  8   cart data out (bank number or write byte)
// - cart_tran_bank1_dir  out  1   1 = FPGA drives data bus
// BEHAVIOUR
// - Reset: rd_data=0, cart_address=0, bank1_out=0, dir=0, read/write=0 (bank0_out=4'b0110), busy=0,
//   bank_valid=0, state=IDLE; reset mid-transaction aborts immediately to these values, bus released.
// - Edge detect: prev_rd/prev_wr registered each cycle; rising edge sampled only in IDLE.
// - Simultaneous rd and wr edges: read serviced, write dropped. Edges while busy=1 dropped.
// - Capture in IDLE: addr, wr_data, op; busy<=1 next cycle. bank = addr >> BANK_ADDR_BITS (8-bit).
// - Out of range (bank >= BANK_COUNT): no cart cycle; read returns 8'hFF; write discarded; COMPLETE next cycle.
// - States: IDLE -> [RAM_EN] -> BANK_SET -> ACCESS -> HOLD -> COMPLETE -> IDLE.
// - BANK_SET entered only if !bank_valid or bank != current_bank; else skipped to ACCESS.
//   Drives cart_address=BANK_REG_ADDR, bank1_out=bank, dir=1, cart_write=1 for WRITE_DELAY+1 cycles,
//   then one release cycle (write=0, dir=0); current_bank<=bank, bank_valid<=1.
// - ACCESS: cart_address = SRAM_BASE + addr[BANK_ADDR_BITS-1:0] (zero-extended, 16-bit add).
//   Read: cart_read=1, dir=0, hold READ_DELAY+1 cycles; sample bank1_in into rd_data on last hold cycle.
//   Write: bank1_out=wr_data, dir=1, cart_write=1, hold WRITE_DELAY+1 cycles.
// - COMPLETE: read/write=0, dir=0, busy<=0; back to IDLE. bank1_out retains last value.
// - Hold counter 8-bit down-counter; delays >255 not supported.
// - Latency (rising edge -> busy fall), same bank read: READ_DELAY+4 cycles; bank change adds WRITE_DELAY+2.
// CONFIGURATION
// - CART_RAM_ENABLE_EN defined: first in-range access after reset runs RAM_EN: write 8'h0A to 16'h0000
//   (WRITE_DELAY+1 cycles + release) before BANK_SET; flag cleared only by reset.
// - Not defined: RAM_EN state absent; cartridge RAM enable is the responsibility of the game/boot path.
// TESTING
// - Reset then rd edge addr 0x0000, cart model byte 0x5A -> bank write 0x00@0x4000, read @0xA000, rd_data=0x5A.
// - Reads at 0x1FFF then 0x2000 -> second read preceded by bank write 0x01@0x4000, cart_address=0xA000.
// - Two reads in bank 3 (0x6004, 0x6005) -> only one bank write; second latency = READ_DELAY+4 cycles.
// - wr edge addr 0x4010 data 0xC3 -> bank 0x02 set, cart write 0xC3@0xA010 with dir=1 for 64 cycles.
// - Read addr 0x20000 with BANK_COUNT=16 -> no cart strobes, rd_data=0xFF; rd+wr same-cycle -> read only.
// - reset asserted mid-HOLD -> next cycle bank0_out=4'b0110, dir=0, busy=0; with CART_RAM_ENABLE_EN, 0x0A@0x0000 seen once.

Source files
------------

// File: rtl/cart_sram_transfer.sv
// cart_sram_transfer: bridge-side byte port to banked cartridge SRAM.
// Bridge reads and writes are mapped onto the 0xA000-0xBFFF cart window.
// Before the access, an MBC-style bank-select write to BANK_REG_ADDR is
// issued whenever the required bank differs from the last one written.
// Optional feature macro: CART_RAM_ENABLE_EN. When it is defined, the first
// in-range access after reset first writes 8'h0A to 16'h0000 to enable
// cartridge RAM.
module cart_sram_transfer #(
  parameter int unsigned BANK_ADDR_BITS = 13,
  parameter int unsigned BANK_COUNT     = 16,
  parameter int unsigned READ_DELAY     = 15,
  parameter int unsigned WRITE_DELAY    = 63,
  parameter logic [15:0] BANK_REG_ADDR  = 16'h4000,
  parameter logic [15:0] SRAM_BASE      = 16'hA000
) (
  input  logic        clk_74a,
  input  logic        reset,
  input  logic        bridge_rd,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_8bit_addr,
  input  logic [7:0]  bridge_8bit_wr_data,
  output logic [7:0]  bridge_8bit_rd_data,
  output logic        busy,
  output logic [15:0] cart_address,
  output logic [3:0]  cart_tran_bank0_out,
  input  logic [7:0]  cart_tran_bank1_in,
  output logic [7:0]  cart_tran_bank1_out,
  output logic        cart_tran_bank1_dir
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BANK_SET,
    ST_ACCESS,
    ST_HOLD,
    ST_COMPLETE
`ifdef CART_RAM_ENABLE_EN
    , ST_RAM_EN
`endif
  } state_t;

  // Hold counter reload values (8-bit counter; delays above 255 unsupported).
  localparam logic [7:0] RD_HOLD = 8'(READ_DELAY);
  localparam logic [7:0] WR_HOLD = 8'(WRITE_DELAY);

  state_t                    state, state_d;
  logic [BANK_ADDR_BITS-1:0] offset_q, offset_d;
  logic [7:0]                bank_q, bank_d;
  logic                      is_write_q, is_write_d;
  logic [7:0]                wr_data_q, wr_data_d;
  logic [7:0]                rd_data_d;
  logic [15:0]               cart_address_d;
  logic [7:0]                bank1_out_d;
  logic                      dir_d;
  logic                      cart_read, cart_read_d;
  logic                      cart_write, cart_write_d;
  logic                      busy_d;
  logic [7:0]                cnt, cnt_d;
  logic [7:0]                current_bank, current_bank_d;
  logic                      bank_valid, bank_valid_d;
  logic                      prev_rd, prev_wr;
`ifdef CART_RAM_ENABLE_EN
  logic                      ram_en_done, ram_en_done_d;
  logic                      bank_change_q;
`endif

  // Request decode straight from the bridge inputs, used only in IDLE.
  // The range test uses the full shifted address so that huge addresses are
  // not aliased into a valid bank by the 8-bit truncation.
  logic [31:0] req_bank_full;
  logic [7:0]  req_bank;
  logic        req_in_range;
  logic        rd_rise, wr_rise;
  logic        req_bank_change;

  assign req_bank_full   = bridge_8bit_addr >> BANK_ADDR_BITS;
  assign req_bank        = req_bank_full[7:0];
  assign req_in_range    = req_bank_full < BANK_COUNT;
  assign rd_rise         = bridge_rd & ~prev_rd;
  assign wr_rise         = bridge_wr & ~prev_wr;
  assign req_bank_change = !bank_valid || (req_bank != current_bank);
`ifdef CART_RAM_ENABLE_EN
  assign bank_change_q   = !bank_valid || (bank_q != current_bank);
`endif

  // Cart control nibble: {unused, WR_n, RD_n, CS}.
  assign cart_tran_bank0_out = {1'b0, ~cart_write, ~cart_read, cart_write};

  // Strobe history for edge detection, kept running through reset.
  always_ff @(posedge clk_74a) begin
    prev_rd <= bridge_rd;
    prev_wr <= bridge_wr;
  end

  // Next-state and next-output logic.
  // Strobes are released one cycle before the phase changes, which gives the
  // cartridge a clean release cycle between consecutive bus cycles.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d        = state;
    offset_d       = offset_q;
    bank_d         = bank_q;
    is_write_d     = is_write_q;
    wr_data_d      = wr_data_q;
    rd_data_d      = bridge_8bit_rd_data;
    cart_address_d = cart_address;
    bank1_out_d    = cart_tran_bank1_out;
    dir_d          = cart_tran_bank1_dir;
    cart_read_d    = cart_read;
    cart_write_d   = cart_write;
    busy_d         = busy;
    cnt_d          = cnt;
    current_bank_d = current_bank;
    bank_valid_d   = bank_valid;
`ifdef CART_RAM_ENABLE_EN
    ram_en_done_d  = ram_en_done;
`endif

    case (state)
      ST_IDLE: begin
        if (rd_rise || wr_rise) begin
          // A read wins over a simultaneous write.
          is_write_d = !rd_rise;
          offset_d   = bridge_8bit_addr[BANK_ADDR_BITS-1:0];
          bank_d     = req_bank;
          wr_data_d  = bridge_8bit_wr_data;
          busy_d     = 1'b1;
          if (!req_in_range) begin
            if (rd_rise) rd_data_d = 8'hFF;
            state_d = ST_COMPLETE;
          end else if (req_bank_change) begin
            cart_address_d = BANK_REG_ADDR;
            bank1_out_d    = req_bank;
            dir_d          = 1'b1;
            cart_write_d   = 1'b1;
            cnt_d          = WR_HOLD;
            state_d        = ST_BANK_SET;
          end else begin
            state_d = ST_ACCESS;
          end
`ifdef CART_RAM_ENABLE_EN
          // RAM enable precedes everything else on the first in-range access.
          if (req_in_range && !ram_en_done) begin
            cart_address_d = 16'h0000;
            bank1_out_d    = 8'h0A;
            dir_d          = 1'b1;
            cart_write_d   = 1'b1;
            cnt_d          = WR_HOLD;
            state_d        = ST_RAM_EN;
          end
`endif
        end
      end

`ifdef CART_RAM_ENABLE_EN
      ST_RAM_EN: begin
        if (cart_write) begin
          if (cnt == 8'd0) begin
            cart_write_d = 1'b0;
            dir_d        = 1'b0;
          end else begin
            cnt_d = cnt - 8'd1;
          end
        end else begin
          ram_en_done_d = 1'b1;
          if (bank_change_q) begin
            cart_address_d = BANK_REG_ADDR;
            bank1_out_d    = bank_q;
            dir_d          = 1'b1;
            cart_write_d   = 1'b1;
            cnt_d          = WR_HOLD;
            state_d        = ST_BANK_SET;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
`endif

      ST_BANK_SET: begin
        if (cart_write) begin
          if (cnt == 8'd0) begin
            cart_write_d = 1'b0;
            dir_d        = 1'b0;
          end else begin
            cnt_d = cnt - 8'd1;
          end
        end else begin
          current_bank_d = bank_q;
          bank_valid_d   = 1'b1;
          state_d        = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        cart_address_d = SRAM_BASE + 16'(offset_q);
        if (is_write_q) begin
          bank1_out_d  = wr_data_q;
          dir_d        = 1'b1;
          cart_write_d = 1'b1;
          cnt_d        = WR_HOLD;
        end else begin
          dir_d       = 1'b0;
          cart_read_d = 1'b1;
          cnt_d       = RD_HOLD;
        end
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (cnt != 8'd0) begin
          cnt_d = cnt - 8'd1;
        end else begin
          // Last hold cycle: read data is stable on the bus now.
          if (!is_write_q) rd_data_d = cart_tran_bank1_in;
          cart_read_d  = 1'b0;
          cart_write_d = 1'b0;
          dir_d        = 1'b0;
          state_d      = ST_COMPLETE;
        end
      end

      ST_COMPLETE: begin
        cart_read_d  = 1'b0;
        cart_write_d = 1'b0;
        dir_d        = 1'b0;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction and frees the bus.
  always_ff @(posedge clk_74a) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state               <= ST_IDLE;
      offset_q            <= '0;
      bank_q              <= 8'd0;
      is_write_q          <= 1'b0;
      wr_data_q           <= 8'd0;
      bridge_8bit_rd_data <= 8'd0;
      cart_address        <= 16'd0;
      cart_tran_bank1_out <= 8'd0;
      cart_tran_bank1_dir <= 1'b0;
      cart_read           <= 1'b0;
      cart_write          <= 1'b0;
      busy                <= 1'b0;
      cnt                 <= 8'd0;
      current_bank        <= 8'd0;
      bank_valid          <= 1'b0;
`ifdef CART_RAM_ENABLE_EN
      ram_en_done         <= 1'b0;
`endif
    end else begin
      state               <= state_d;
      offset_q            <= offset_d;
      bank_q              <= bank_d;
      is_write_q          <= is_write_d;
      wr_data_q           <= wr_data_d;
      bridge_8bit_rd_data <= rd_data_d;
      cart_address        <= cart_address_d;
      cart_tran_bank1_out <= bank1_out_d;
      cart_tran_bank1_dir <= dir_d;
      cart_read           <= cart_read_d;
      cart_write          <= cart_write_d;
      busy                <= busy_d;
      cnt                 <= cnt_d;
      current_bank        <= current_bank_d;
      bank_valid          <= bank_valid_d;
`ifdef CART_RAM_ENABLE_EN
      ram_en_done         <= ram_en_done_d;
`endif
    end
  end

endmodule
